// File: rtl/fpu_resp_arbiter.sv
// Buffered round-robin response scheduler: one pending beat per FPU/APU unit,
// serialised onto a single registered core-side channel with valid/ready.

module fpu_resp_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [FLAG_WIDTH-1:0] flag_i,
  input  logic                  grant_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [FLAG_WIDTH-1:0] flag_o
);
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [FLAG_WIDTH-1:0] flag_q, flag_d;

  // Grant and capture are mutually exclusive: capture needs ~full, grant needs full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    flag_d = flag_q;
    if (grant_i) begin
      full_d = 1'b0;
    end else if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
      flag_d = flag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      flag_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      flag_q <= flag_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign flag_o = flag_q;
endmodule

module fpu_resp_arbiter #(
  parameter int  NB_APUS    = 16,
  parameter int  FLAG_WIDTH = 8,
  parameter int  DATA_WIDTH = 32,
  localparam int ID_WIDTH   = $clog2(NB_APUS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NB_APUS-1:0]               apu_valid_i,
  input  logic [NB_APUS*DATA_WIDTH-1:0]    apu_rdata_i,
  input  logic [NB_APUS*FLAG_WIDTH-1:0]    apu_flag_i,
  output logic [NB_APUS-1:0]               apu_ready_o,
  output logic                             resp_valid_o,
  output logic [DATA_WIDTH-1:0]            resp_rdata_o,
  output logic [FLAG_WIDTH-1:0]            resp_flag_o,
  output logic [ID_WIDTH-1:0]              resp_id_o,
  input  logic                             resp_ready_i,
  output logic                             busy_o,
  output logic                             err_o
);
  localparam int IW1 = ID_WIDTH + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic [FLAG_WIDTH-1:0] flag;
  } beat_t;

  logic [NB_APUS-1:0]                 full, grant;
  logic [NB_APUS-1:0][DATA_WIDTH-1:0] slot_data;
  logic [NB_APUS-1:0][FLAG_WIDTH-1:0] slot_flag;

  for (genvar i = 0; i < NB_APUS; i++) begin : g_slot
    fpu_resp_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .FLAG_WIDTH(FLAG_WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid_i(apu_valid_i[i]),
      .data_i (apu_rdata_i[i*DATA_WIDTH +: DATA_WIDTH]),
      .flag_i (apu_flag_i[i*FLAG_WIDTH +: FLAG_WIDTH]),
      .grant_i(grant[i]),
      .full_o (full[i]),
      .data_o (slot_data[i]),
      .flag_o (slot_flag[i])
    );
  end

  logic                rr_ptr_q, unused_rr;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic                resp_valid_q, resp_valid_d;
  beat_t               resp_beat_q, resp_beat_d;
  logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;
  logic                err_q, err_d;
  logic                out_free, found, do_grant;
  logic [ID_WIDTH-1:0] gnt_id;
  logic [IW1-1:0]      idx;

  assign rr_ptr_q  = 1'b0;
  assign unused_rr = rr_ptr_q;

  // Rotating search without a power-of-two wrap: rr + k folded back below NB_APUS.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NB_APUS; k++) begin
      idx = {1'b0, rr_q} + IW1'(k);
      if (idx >= IW1'(NB_APUS)) idx = idx - IW1'(NB_APUS);
      if (!found && full[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[ID_WIDTH-1:0];
      end
    end
  end

  assign out_free = ~resp_valid_q | resp_ready_i;
  assign do_grant = out_free & found;

  always_comb begin
    grant        = '0;
    rr_d         = rr_q;
    resp_valid_d = resp_valid_q;
    resp_beat_d  = resp_beat_q;
    resp_id_d    = resp_id_q;
    err_d        = err_q | (|(apu_valid_i & full));
    if (do_grant) begin
      grant[gnt_id]     = 1'b1;
      rr_d              = (gnt_id == ID_WIDTH'(NB_APUS-1)) ? '0 : gnt_id + ID_WIDTH'(1);
      resp_valid_d      = 1'b1;
      resp_beat_d.rdata = slot_data[gnt_id];
      resp_beat_d.flag  = slot_flag[gnt_id];
      resp_id_d         = gnt_id;
    end else if (out_free) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_beat_q  <= '0;
      resp_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_beat_q  <= resp_beat_d;
      resp_id_q    <= resp_id_d;
      err_q        <= err_d;
    end
  end

  assign apu_ready_o  = ~full;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_beat_q.rdata;
  assign resp_flag_o  = resp_beat_q.flag;
  assign resp_id_o    = resp_id_q;
  assign busy_o       = (|full) | resp_valid_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_fpu_resp_arbiter.sv
// Directed bench for fpu_resp_arbiter: inputs driven and outputs sampled 1ns after rising edges.

module tb_fpu_resp_arbiter;
  localparam int NB = 16;
  localparam int FW = 8;
  localparam int DW = 32;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NB-1:0]     apu_valid;
  logic [NB*DW-1:0]  apu_rdata;
  logic [NB*FW-1:0]  apu_flag;
  logic [NB-1:0]     apu_ready;
  logic              resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic [FW-1:0]     resp_flag;
  logic [IW-1:0]     resp_id;
  logic              resp_ready;
  logic              busy, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_resp_arbiter #(.NB_APUS(NB), .FLAG_WIDTH(FW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apu_valid_i (apu_valid),
    .apu_rdata_i (apu_rdata),
    .apu_flag_i  (apu_flag),
    .apu_ready_o (apu_ready),
    .resp_valid_o(resp_valid),
    .resp_rdata_o(resp_rdata),
    .resp_flag_o (resp_flag),
    .resp_id_o   (resp_id),
    .resp_ready_i(resp_ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  // {valid, id, data, flag}
  wire [44:0] beat = {resp_valid, resp_id, resp_rdata, resp_flag};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    apu_valid = '0;
    apu_rdata = '0;
    apu_flag  = '0;
  endtask

  task automatic set_beat(input int u, input logic [DW-1:0] d, input logic [FW-1:0] f);
    apu_valid[u]         = 1'b1;
    apu_rdata[u*DW +: DW] = d;
    apu_flag[u*FW +: FW]  = f;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clr_in();
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({beat, busy, err, apu_ready} !== {45'd0, 1'b0, 1'b0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", {beat, busy, err, apu_ready}, {45'd0, 2'b00, 16'hFFFF});
    end
  endtask

  task automatic test_single;
    set_beat(3, 32'hDEADBEEF, 8'h05);
    tick();
    clr_in();
    checks++;
    if ({resp_valid, apu_ready[3], busy} !== 3'b001) begin
      errors++;
      $display("FAIL single_captured got=%b exp=001", {resp_valid, apu_ready[3], busy});
    end
    tick();
    checks++;
    if ({beat, apu_ready[3]} !== {1'b1, 4'd3, 32'hDEADBEEF, 8'h05, 1'b1}) begin
      errors++;
      $display("FAIL single_beat got=%h exp=%h", {beat, apu_ready[3]}, {1'b1, 4'd3, 32'hDEADBEEF, 8'h05, 1'b1});
    end
    tick();
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_done got=%b exp=00", {resp_valid, busy});
    end
  endtask

  task automatic test_burst;
    logic [44:0] exp;
    do_reset();
    for (int i = 0; i < NB; i++) set_beat(i, 32'h100 + 32'(i), 8'(i));
    tick();
    clr_in();
    checks++;
    if ({resp_valid, busy, apu_ready} !== {1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL burst_captured got=%h exp=%h", {resp_valid, busy, apu_ready}, {2'b01, 16'h0});
    end
    for (int k = 0; k < NB; k++) begin
      tick();
      exp = {1'b1, 4'(k), 32'h100 + 32'(k), 8'(k)};
      checks++;
      if (beat !== exp) begin
        errors++;
        $display("FAIL burst_beat k=%0d got=%h exp=%h", k, beat, exp);
      end
    end
    tick();
    checks++;
    if ({resp_valid, busy, err} !== 3'b000) begin
      errors++;
      $display("FAIL burst_done got=%b exp=000", {resp_valid, busy, err});
    end
  endtask

  task automatic test_rr_wrap;
    int order [3] = '{14, 15, 2};
    logic [44:0] exp;
    // Granting unit 13 alone leaves the pointer at 14.
    set_beat(13, 32'h13, 8'h13);
    tick();
    clr_in();
    tick();
    set_beat(2, 32'h202, 8'h02);
    set_beat(14, 32'h20E, 8'h0E);
    set_beat(15, 32'h20F, 8'h0F);
    tick();
    clr_in();
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = {1'b1, 4'(order[k]), 32'h200 + 32'(order[k]), 8'(order[k])};
      checks++;
      if (beat !== exp) begin
        errors++;
        $display("FAIL rr_wrap k=%0d got=%h exp=%h", k, beat, exp);
      end
    end
    // Pointer must now be 3: unit 3 beats unit 2.
    set_beat(2, 32'h302, 8'h22);
    set_beat(3, 32'h303, 8'h33);
    tick();
    clr_in();
    tick();
    checks++;
    if (beat !== {1'b1, 4'd3, 32'h303, 8'h33}) begin
      errors++;
      $display("FAIL rr_ptr_end got=%h exp=%h", beat, {1'b1, 4'd3, 32'h303, 8'h33});
    end
    tick();
    checks++;
    if (beat !== {1'b1, 4'd2, 32'h302, 8'h22}) begin
      errors++;
      $display("FAIL rr_ptr_next got=%h exp=%h", beat, {1'b1, 4'd2, 32'h302, 8'h22});
    end
    tick();
  endtask

  task automatic test_backpressure;
    resp_ready = 1'b0;
    set_beat(0, 32'hA0, 8'h10);
    set_beat(1, 32'hA1, 8'h11);
    tick();
    clr_in();
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({beat, apu_ready[1:0]} !== {1'b1, 4'd0, 32'hA0, 8'h10, 2'b01}) begin
        errors++;
        $display("FAIL bp_hold c=%0d got=%h exp=%h", c, {beat, apu_ready[1:0]}, {1'b1, 4'd0, 32'hA0, 8'h10, 2'b01});
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (beat !== {1'b1, 4'd1, 32'hA1, 8'h11}) begin
      errors++;
      $display("FAIL bp_release got=%h exp=%h", beat, {1'b1, 4'd1, 32'hA1, 8'h11});
    end
    tick();
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bp_done got=%b exp=00", {resp_valid, busy});
    end
  endtask

  task automatic test_proto_err;
    resp_ready = 1'b0;
    set_beat(6, 32'h600, 8'h66);
    set_beat(7, 32'h700, 8'h77);
    tick();
    clr_in();
    set_beat(7, 32'hBAD, 8'hEE);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_early got=%b exp=0", err);
    end
    tick();
    checks++;
    if ({err, beat} !== {1'b1, 1'b1, 4'd6, 32'h600, 8'h66}) begin
      errors++;
      $display("FAIL err_rise got=%h exp=%h", {err, beat}, {1'b1, 1'b1, 4'd6, 32'h600, 8'h66});
    end
    tick();
    clr_in();
    tick();
    checks++;
    if ({err, apu_ready[7]} !== 2'b10) begin
      errors++;
      $display("FAIL err_sticky got=%b exp=10", {err, apu_ready[7]});
    end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (beat !== {1'b1, 4'd7, 32'h700, 8'h77}) begin
      errors++;
      $display("FAIL err_payload got=%h exp=%h", beat, {1'b1, 4'd7, 32'h700, 8'h77});
    end
    tick();
    checks++;
    if ({err, resp_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL err_after got=%b exp=100", {err, resp_valid, busy});
    end
  endtask

  task automatic test_reset_mid;
    resp_ready = 1'b0;
    set_beat(5, 32'h55, 8'h05);
    set_beat(9, 32'h99, 8'h09);
    set_beat(10, 32'hAA, 8'h0A);
    set_beat(12, 32'hCC, 8'h0C);
    tick();
    clr_in();
    tick();
    checks++;
    if ({resp_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre got=%b exp=11", {resp_valid, busy});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({beat, busy, err, apu_ready} !== {45'd0, 2'b00, 16'hFFFF}) begin
      errors++;
      $display("FAIL rstmid_async got=%h exp=%h", {beat, busy, err, apu_ready}, {45'd0, 2'b00, 16'hFFFF});
    end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    tick();
    set_beat(15, 32'hF15, 8'hF1);
    set_beat(3, 32'hF03, 8'hF3);
    tick();
    clr_in();
    tick();
    checks++;
    if (beat !== {1'b1, 4'd3, 32'hF03, 8'hF3}) begin
      errors++;
      $display("FAIL rstmid_first got=%h exp=%h", beat, {1'b1, 4'd3, 32'hF03, 8'hF3});
    end
    tick();
    checks++;
    if (beat !== {1'b1, 4'd15, 32'hF15, 8'hF1}) begin
      errors++;
      $display("FAIL rstmid_second got=%h exp=%h", beat, {1'b1, 4'd15, 32'hF15, 8'hF1});
    end
  endtask

  initial begin
    clr_in();
    resp_ready = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_rr_wrap();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
